// File: rtl/bus_mem_responder_pkg.sv
// Shared types and helpers for the req/gnt/rvalid memory responder.
// Response payloads travel through the latency pipeline as bus_resp_t.
package bus_mem_responder_pkg;

    localparam int BUS_WORD_BYTES = 4;
    localparam int BUS_ADDR_W     = 32;
    localparam int BUS_DATA_W     = 8 * BUS_WORD_BYTES;

    typedef struct packed {
        logic [BUS_DATA_W-1:0] rdata;
        logic                  err;
    } bus_resp_t;

    localparam bus_resp_t BUS_RESP_IDLE = '{rdata: '0, err: 1'b0};

    // Replace only the enabled byte lanes of old_word with new_word.
    function automatic logic [BUS_DATA_W-1:0] merge_bytes(
        input logic [BUS_DATA_W-1:0]     old_word,
        input logic [BUS_DATA_W-1:0]     new_word,
        input logic [BUS_WORD_BYTES-1:0] be
    );
        logic [BUS_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < BUS_WORD_BYTES; k++) begin
            if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// req/gnt/rvalid bus as driven by the DMA master and answered by the responder.
interface bus_mem_responder_if;
    import bus_mem_responder_pkg::*;

    logic                      req;
    logic                      gnt;
    logic [BUS_ADDR_W-1:0]     addr;
    logic                      we;
    logic [BUS_WORD_BYTES-1:0] be;
    logic [BUS_DATA_W-1:0]     wdata;
    logic                      rvalid;
    logic [BUS_DATA_W-1:0]     rdata;
    logic                      err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/bus_mem_responder_resp_delay_line.sv
// Fixed-latency response pipeline: a valid bit plus payload per stage, cleared by rst_i.
// Empty stages carry an all-zero payload so the output is zero whenever valid is low.
module resp_delay_line
    import bus_mem_responder_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push,
    input  bus_resp_t push_resp,
    output logic      valid,
    output bus_resp_t resp
);

    logic      valid_q [LAT];
    bus_resp_t resp_q  [LAT];

    // NOTE: non-blocking assignments let every stage read its neighbour's old value, so the shift order inside the loop does not matter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                resp_q[i]  <= BUS_RESP_IDLE;
            end
        end else begin
            valid_q[0] <= push;
            resp_q[0]  <= push ? push_resp : BUS_RESP_IDLE;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign valid = valid_q[LAT-1];
    assign resp  = resp_q[LAT-1];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-backed responder for the req/gnt/rvalid bus with configurable grant wait
// states, fixed response latency and external stall.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          GNT_WAIT    = 0,
    parameter int          RVALID_LAT  = 1
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          stall_i,
    bus_mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33 bits so a window ending exactly at 4 GiB still compares correctly.
    localparam logic [BUS_ADDR_W:0] END_ADDR =
        {1'b0, BASE_ADDR} + (33'(BUS_WORD_BYTES) * 33'(DEPTH_WORDS));

    if (GNT_WAIT < 0 || GNT_WAIT > 15) begin : g_bad_gnt_wait
        $error("bus_mem_responder: GNT_WAIT=%0d outside 0..15", GNT_WAIT);
    end
    if (RVALID_LAT < 1 || RVALID_LAT > 8) begin : g_bad_rvalid_lat
        $error("bus_mem_responder: RVALID_LAT=%0d outside 1..8", RVALID_LAT);
    end
    if (DEPTH_WORDS < 1 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("bus_mem_responder: DEPTH_WORDS=%0d is not a power of two", DEPTH_WORDS);
    end

    logic [3:0]            wait_cnt;
    logic                  grant;
    logic                  dec_err;
    logic [IDX_W-1:0]      word_idx;
    bus_resp_t             push_resp;
    logic                  out_valid;
    bus_resp_t             out_resp;
    logic [BUS_DATA_W-1:0] mem [DEPTH_WORDS];

    assign grant   = bus.req & ~stall_i & ~rst_i & (wait_cnt == 4'(GNT_WAIT));
    assign bus.gnt = grant;

    // The counter only ever climbs to GNT_WAIT, so "not there yet" is an inequality test.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (!bus.req || grant) begin
            wait_cnt <= '0;
        end else if (!stall_i && wait_cnt != 4'(GNT_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        dec_err   = 1'b0;
        word_idx  = '0;
        push_resp = BUS_RESP_IDLE;

        dec_err = (bus.addr < BASE_ADDR)
                | ({1'b0, bus.addr} >= END_ADDR)
                | (bus.addr[1:0] != 2'b00);
        word_idx = IDX_W'((bus.addr - BASE_ADDR) >> 2);

        push_resp.err = dec_err;
        if (!dec_err && !bus.we) push_resp.rdata = mem[word_idx];
    end

    // NOTE: the storage array has no reset branch; contents survive rst_i and start undefined, as a real RAM would.
    always_ff @(posedge clk_i) begin
        if (grant && bus.we && !dec_err) begin
            mem[word_idx] <= merge_bytes(mem[word_idx], bus.wdata, bus.be);
        end
    end

    resp_delay_line #(
        .LAT (RVALID_LAT)
    ) u_resp_delay (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (grant),
        .push_resp (push_resp),
        .valid     (out_valid),
        .resp      (out_resp)
    );

    assign bus.rvalid = out_valid;
    assign bus.rdata  = out_resp.rdata;
    assign bus.err    = out_resp.err;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: three instances cover default timing,
// wait states with long latency, and reset with responses in flight.
module tb_bus_mem_responder;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic stall_a, stall_b, stall_c;
    int   n_asserts;
    int   n_fail;

    bus_mem_responder_if bus_a ();
    bus_mem_responder_if bus_b ();
    bus_mem_responder_if bus_c ();

    bus_mem_responder u_dut_a (
        .clk_i   (clk),
        .rst_i   (rst_a),
        .stall_i (stall_a),
        .bus     (bus_a)
    );

    bus_mem_responder #(
        .GNT_WAIT   (3),
        .RVALID_LAT (4)
    ) u_dut_b (
        .clk_i   (clk),
        .rst_i   (rst_b),
        .stall_i (stall_b),
        .bus     (bus_b)
    );

    bus_mem_responder #(
        .GNT_WAIT   (0),
        .RVALID_LAT (4)
    ) u_dut_c (
        .clk_i   (clk),
        .rst_i   (rst_c),
        .stall_i (stall_c),
        .bus     (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        bus_a.req   = req;
        bus_a.we    = we;
        bus_a.addr  = addr;
        bus_a.be    = be;
        bus_a.wdata = wdata;
    endtask

    // One isolated transfer on instance A (GNT_WAIT=0, RVALID_LAT=1).
    task automatic a_single(input string tag, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        tick;
        set_a(1'b1, we, addr, be, wdata);
        #1;
        check_bit({tag, "_gnt"}, bus_a.gnt, 1'b1);
        tick;
        set_a(1'b0, we, addr, be, wdata);
        #1;
        check_bit({tag, "_rvalid"}, bus_a.rvalid, 1'b1);
        check({tag, "_rdata"}, bus_a.rdata, exp_rdata);
        check_bit({tag, "_err"}, bus_a.err, exp_err);
    endtask

    logic        exp_gnt;
    logic        exp_rv;
    logic [31:0] exp_rdata;
    int          k;
    int          j;

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
        set_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = 32'h0; bus_b.be = 4'hF; bus_b.wdata = 32'h0;
        bus_c.req = 1'b0; bus_c.we = 1'b0; bus_c.addr = 32'h0; bus_c.be = 4'hF; bus_c.wdata = 32'h0;

        // Reset state; a request held during reset is never granted.
        tick;
        tick;
        set_a(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        #1;
        check_bit("rst_gnt_a", bus_a.gnt, 1'b0);
        check_bit("rst_rvalid_a", bus_a.rvalid, 1'b0);
        check("rst_rdata_a", bus_a.rdata, 32'h0);
        check_bit("rst_err_a", bus_a.err, 1'b0);
        check_bit("rst_rvalid_b", bus_b.rvalid, 1'b0);
        check_bit("rst_rvalid_c", bus_c.rvalid, 1'b0);
        set_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Basic write then read.
        a_single("a_wr10", 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        a_single("a_rd10", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Back-to-back: full write, masked write, read in consecutive cycles.
        tick;
        set_a(1'b1, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        #1;
        check_bit("a_be_w1_gnt", bus_a.gnt, 1'b1);
        tick;
        set_a(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        #1;
        check_bit("a_be_w2_gnt", bus_a.gnt, 1'b1);
        check_bit("a_be_w1_rvalid", bus_a.rvalid, 1'b1);
        check("a_be_w1_rdata", bus_a.rdata, 32'h0);
        tick;
        set_a(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        #1;
        check_bit("a_be_rd_gnt", bus_a.gnt, 1'b1);
        check_bit("a_be_w2_rvalid", bus_a.rvalid, 1'b1);
        tick;
        set_a(1'b0, 1'b0, 32'h20, 4'h0, 32'h0);
        #1;
        check_bit("a_be_rd_rvalid", bus_a.rvalid, 1'b1);
        check("a_be_rd_rdata", bus_a.rdata, 32'h11BB_33DD);
        check_bit("a_be_rd_err", bus_a.err, 1'b0);

        // be=0 write changes nothing.
        a_single("a_wr20_be0", 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        a_single("a_rd20_be0", 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0);

        // Window edges and error responses.
        a_single("a_wr0", 1'b1, 32'h0, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        a_single("a_wrffc", 1'b1, 32'hFFC, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
        a_single("a_rdffc", 1'b0, 32'hFFC, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
        a_single("a_rd1002", 1'b0, 32'h1002, 4'hF, 32'h0, 32'h0, 1'b1);
        a_single("a_rd1000", 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1);
        a_single("a_wr1000", 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        a_single("a_wr12", 1'b1, 32'h12, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        a_single("a_rd0_after_oor", 1'b0, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
        a_single("a_rd10_after_mis", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Stall for 5 cycles with req held, grant in the first cycle after it drops.
        tick;
        stall_a = 1'b1;
        set_a(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            #1;
            check_bit($sformatf("a_stall%0d_gnt", i), bus_a.gnt, 1'b0);
            check_bit($sformatf("a_stall%0d_rvalid", i), bus_a.rvalid, 1'b0);
        end
        tick;
        stall_a = 1'b0;
        #1;
        check_bit("a_unstall_gnt", bus_a.gnt, 1'b1);
        tick;
        set_a(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
        #1;
        check_bit("a_unstall_rvalid", bus_a.rvalid, 1'b1);
        check("a_unstall_rdata", bus_a.rdata, 32'hDEAD_BEEF);

        // Instance B: GNT_WAIT=3, RVALID_LAT=4. Pass 0 writes words 0..3, pass 1 reads them.
        // req held continuously: grants at cycles 3,7,11,15; responses at 7,11,15,19.
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 24; c++) begin
                tick;
                k = c / 4;
                bus_b.req   = (c < 16);
                bus_b.we    = (pass == 0);
                bus_b.addr  = (c < 16) ? 32'(4 * k) : 32'h0;
                bus_b.be    = 4'hF;
                bus_b.wdata = 32'hC0DE_0000 + 32'(k);
                #1;
                exp_gnt   = (c < 16) && (c % 4 == 3);
                exp_rv    = (c >= 7) && (c <= 19) && ((c - 7) % 4 == 0);
                j         = (c - 7) / 4;
                exp_rdata = (exp_rv && pass == 1) ? 32'hC0DE_0000 + 32'(j) : 32'h0;
                check_bit($sformatf("b_p%0d_c%0d_gnt", pass, c), bus_b.gnt, exp_gnt);
                check_bit($sformatf("b_p%0d_c%0d_rvalid", pass, c), bus_b.rvalid, exp_rv);
                check($sformatf("b_p%0d_c%0d_rdata", pass, c), bus_b.rdata, exp_rdata);
                check_bit($sformatf("b_p%0d_c%0d_err", pass, c), bus_b.err, 1'b0);
            end
        end

        // Instance C: GNT_WAIT=0, RVALID_LAT=4. Preload word 0x40.
        for (int c = 0; c < 8; c++) begin
            tick;
            bus_c.req = (c == 0); bus_c.we = 1'b1; bus_c.addr = 32'h40; bus_c.wdata = 32'h5A5A_A5A5;
            #1;
            check_bit($sformatf("c_wr_c%0d_gnt", c), bus_c.gnt, c == 0);
            check_bit($sformatf("c_wr_c%0d_rvalid", c), bus_c.rvalid, c == 4);
            check($sformatf("c_wr_c%0d_rdata", c), bus_c.rdata, 32'h0);
        end

        // Two grants at cycles 0,1; reset in cycle 3, just before the first response is due.
        for (int c = 0; c < 12; c++) begin
            tick;
            bus_c.req = (c < 2); bus_c.we = 1'b0; bus_c.addr = 32'h40;
            rst_c = (c == 3);
            #1;
            check_bit($sformatf("c_rst_c%0d_gnt", c), bus_c.gnt, c < 2);
            check_bit($sformatf("c_rst_c%0d_rvalid", c), bus_c.rvalid, 1'b0);
            check($sformatf("c_rst_c%0d_rdata", c), bus_c.rdata, 32'h0);
        end

        // Normal read after reset; memory contents survive reset.
        for (int c = 0; c < 8; c++) begin
            tick;
            bus_c.req = (c == 0); bus_c.we = 1'b0; bus_c.addr = 32'h40;
            #1;
            check_bit($sformatf("c_post_c%0d_gnt", c), bus_c.gnt, c == 0);
            check_bit($sformatf("c_post_c%0d_rvalid", c), bus_c.rvalid, c == 4);
            check($sformatf("c_post_c%0d_rdata", c), bus_c.rdata, (c == 4) ? 32'h5A5A_A5A5 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-backed responder for the req/gnt/rvalid bus used by the cipher peripheral's DMA master port.
- Receives master_* traffic: accepts requests, stores/returns 32-bit words, and signals errors.
- Provides configurable grant wait states, response latency and external stall, so DMA paths can be exercised and integrated without a system interconnect.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of backing storage (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
- GNT_WAIT, 0, idle cycles req_i must be held before gnt_o may assert (0..15).
- RVALID_LAT, 1, cycles from grant edge to rvalid_o (1..8).

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- req_i  in  1  request valid from master
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address
- we_i  in  1  1=write, 0=read
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- stall_i  in  1  external backpressure; forces gnt_o=0
- rvalid_o  out  1  response valid, one cycle per granted request
- rdata_o  out  32  read data (0 for writes and errors)
- err_o  out  1  response error, qualified by rvalid_o

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high; it is sampled only on clk_i rising edges.
- Reset:
  - rvalid_o=0, rdata_o=0, err_o=0, wait counter=0, delay line cleared.
  - gnt_o=0 while rst_i=1.
  - Memory contents are not reset.
- Grant:
  - gnt_o = req_i & ~stall_i & ~rst_i & (wait_cnt==GNT_WAIT), combinational.
  - wait_cnt increments while req_i=1 and wait_cnt<GNT_WAIT.
  - wait_cnt clears to 0 on grant or when req_i=0.
  - stall_i=1 holds wait_cnt.
  - GNT_WAIT=0 grants in the same cycle as req_i, absent stall.
- Handshake: a transfer occurs in a cycle with req_i&gnt_o. The master holds addr/we/be/wdata stable until granted; the responder does not check this. At most one grant per cycle.
- Decode:
  - err = (addr_i<BASE_ADDR) | (addr_i>=BASE_ADDR+4*DEPTH_WORDS) | (addr_i[1:0]!=0).
  - Index = (addr_i-BASE_ADDR)>>2, truncated to $clog2(DEPTH_WORDS) bits.
- Write: on a granted, non-error write, the bytes with be_i[k]=1 are written at the grant edge. be_i=0 is legal and leaves memory unchanged. The response is rdata=0, err=0.
- Read: on a granted, non-error read, the full word is returned regardless of be_i. The read is sampled at the grant edge, so a read granted the cycle after a write to the same word returns the new data.
- Error: no memory access; response is err=1, rdata=0.
- Response: each grant pushes {rdata, err} into an RVALID_LAT-stage delay line. rvalid_o/rdata_o/err_o appear exactly RVALID_LAT cycles after the grant edge, in grant order, for back-to-back grants every cycle. There is no response backpressure. When rvalid_o=0, rdata_o=0 and err_o=0.
- Reset mid-operation: all in-flight responses are dropped; no rvalid_o for them after reset.
- Illegal parameters (GNT_WAIT>15, RVALID_LAT<1 or >8, DEPTH_WORDS not a power of two) trigger an elaboration-time $error.

Decomposition:
- cipher_pkg gains:
  - typedef bus_resp_t {logic [31:0] rdata; logic err;}
  - constant BUS_WORD_BYTES=4
- Sub-module resp_delay_line, parameterised by LAT: a valid plus bus_resp_t shift pipeline with synchronous clear.
- The top contains the wait counter, decode, byte-masked memory array and grant logic.

Test Plan:
- Default params: write 32'hDEAD_BEEF to 0x10 with be=4'hF, then read 0x10 -> gnt in the req cycle; read rvalid 1 cycle after grant with rdata=32'hDEAD_BEEF, err=0.
- Write 0x11223344 to 0x20, then be=4'b0101 write 0xAABBCCDD, then read -> rdata=32'h11BB33DD.
- GNT_WAIT=3, RVALID_LAT=4, with 4 back-to-back reads of preloaded words 0..3 -> each gnt 3 cycles after req rises; rvalid exactly 4 cycles after each grant, in order, with correct data.
- Read at 0x1002 (misaligned) and at BASE+4*DEPTH_WORDS -> rvalid with err=1, rdata=0; a write to an out-of-range address leaves memory unchanged (verified by readback).
- stall_i high for 5 cycles while req_i=1 -> gnt_o=0 throughout; grant in the first cycle after stall_i drops (GNT_WAIT=0).
- RVALID_LAT=4: two grants, then rst_i pulsed 1 cycle before the first response is due -> no rvalid_o after reset; the next request after reset behaves normally.
